// File: rtl/score_disp_pkg.sv
// score_disp_pkg: shared widths, converter states and 7-segment glyphs
package score_disp_pkg;
  localparam int NUM_DIGITS = 5;
  localparam int SCORE_W = 16;
  localparam int BCD_W = 4 * NUM_DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return 7'b0;
    endcase
  endfunction
endpackage

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: sequential double-dabble binary-to-BCD converter with one-deep newest-wins request buffer
module score_bcd_conv
  import score_disp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_load,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd,
  output logic               bcd_valid
);
  state_e state_q, state_d;
  logic [BCD_W+SCORE_W-1:0] work_q, work_d, adj;
  logic [3:0] iter_q, iter_d;
  logic pend_q, pend_d;
  logic [SCORE_W-1:0] pend_val_q, pend_val_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic valid_q, valid_d;
  // add 3 to every BCD nibble of 5 or more before the shift
  always_comb begin
    adj = work_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (work_q[SCORE_W+4*i +: 4] >= 4'd5) adj[SCORE_W+4*i +: 4] = work_q[SCORE_W+4*i +: 4] + 4'd3;
  end
  // conversion sequencing; a load seen in DONE restarts directly so it is never dropped
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    iter_d = iter_q;
    pend_d = pend_q;
    pend_val_d = pend_val_q;
    bcd_d = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (score_load) begin
        work_d = {BCD_W'(0), score};
        iter_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        work_d = {adj[BCD_W+SCORE_W-2:0], 1'b0};
        iter_d = iter_q + 4'd1;
        state_d = iter_q == 4'd15 ? DONE : SHIFT;
        if (score_load) begin
          pend_d = 1'b1;
          pend_val_d = score;
        end
      end
      DONE: begin
        bcd_d = work_q[BCD_W+SCORE_W-1:SCORE_W];
        valid_d = 1'b1;
        pend_d = 1'b0;
        work_d = {BCD_W'(0), score_load ? score : pend_val_q};
        iter_d = '0;
        state_d = (score_load || pend_q) ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      iter_q <= '0;
      pend_q <= 1'b0;
      pend_val_q <= '0;
      bcd_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      iter_q <= iter_d;
      pend_q <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q <= bcd_d;
      valid_q <= valid_d;
    end
  end
  assign busy = state_q != IDLE;
  assign bcd = bcd_q;
  assign bcd_valid = valid_q;
endmodule

// File: rtl/score_display.sv
// score_display: score to BCD plus 5-digit multiplexed 7-segment drive; SCORE_DISP_BLANK_EN enables leading-zero blanking
module score_display
  import score_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  score_load,
  output logic                  busy,
  output logic [BCD_W-1:0]      bcd,
  output logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] ref_q, ref_d;
  logic [2:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic wrap, blank;
  logic [3:0] digit;
  score_bcd_conv u_conv (
    .clk(clk),
    .rst(rst),
    .score(score),
    .score_load(score_load),
    .busy(busy),
    .bcd(bcd),
    .bcd_valid(bcd_valid)
  );
  // refresh timing, digit rotation and glyph selection, computed for the upcoming index so seg and digit_en move together
  always_comb begin
    wrap = ref_q == CW'(REFRESH_DIV - 1);
    ref_d = wrap ? '0 : ref_q + CW'(1);
    idx_d = wrap ? (idx_q == 3'(NUM_DIGITS - 1) ? 3'd0 : idx_q + 3'd1) : idx_q;
    digit = 4'(bcd >> {idx_d, 2'b00});
`ifdef SCORE_DISP_BLANK_EN
    blank = idx_d != 3'd0 && (bcd >> {idx_d, 2'b00}) == '0;
`else
    blank = 1'b0;
`endif
    seg_d = blank ? 7'b0 : seg_lut(digit);
    en_d = NUM_DIGITS'(1) << idx_d;
  end
  // display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_0;
      en_q <= NUM_DIGITS'(1);
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      en_q <= en_d;
    end
  end
  assign seg = seg_q;
  assign digit_en = en_q;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: vector, random and sequence checks of score_display against a decimal reference model
module tb_score_display;
  localparam int RD = 4;
`ifdef SCORE_DISP_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  logic clk = 0, rst = 1, score_load = 0, busy, bcd_valid;
  logic [15:0] score = 0;
  logic [19:0] bcd;
  logic [6:0] seg;
  logic [4:0] digit_en;
  int checks = 0, failures = 0;
  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  typedef struct {logic [15:0] s; logic [19:0] e;} vec_t;
  vec_t vecs [7];
  score_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .score(score), .score_load(score_load), .busy(busy),
    .bcd(bcd), .bcd_valid(bcd_valid), .seg(seg), .digit_en(digit_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = 0;
    int p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction
  function automatic logic [6:0] exp_seg(input logic [19:0] b, input int i);
    logic [19:0] hi = b >> (4 * i);
    if (BLANK && i > 0 && hi == 0) return 7'b0;
    return glyph[hi[3:0]];
  endfunction
  // called right after a negedge; returns the result, edges from load to valid, and busy cycles
  task automatic do_conv(input logic [15:0] v, output logic [19:0] res, output int lat, output int bcnt);
    score = v;
    score_load = 1;
    @(posedge clk);
    @(negedge clk);
    score_load = 0;
    lat = -1;
    bcnt = 0;
    res = 'x;
    for (int n = 0; n < 40; n++) begin
      if (bcd_valid) begin
        res = bcd;
        lat = n;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask
  task automatic check_scan(input logic [19:0] eb);
    int idx;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5 * RD; c++) begin
      idx = 0;
      for (int b = 0; b < 5; b++) if (digit_en[b]) idx = b;
      chk("scan_onehot", 32'($onehot(digit_en)), 1);
      chk($sformatf("scan_seg_d%0d", idx), 32'(seg), 32'(exp_seg(eb, idx)));
      @(negedge clk);
    end
  endtask
  // load a, optionally load b at sample n1 and c at sample n2; collect valid pulses
  task automatic seq(input logic [15:0] a, input int n1, input logic [15:0] b, input int n2, input logic [15:0] c,
                     input logic [19:0] e0, input logic [19:0] e1, input string name);
    logic [19:0] vals [$];
    int times [$];
    score = a;
    score_load = 1;
    @(posedge clk);
    @(negedge clk);
    score_load = 0;
    for (int n = 0; n < 60; n++) begin
      if (bcd_valid) begin
        vals.push_back(bcd);
        times.push_back(n);
      end
      score_load = (n == n1) || (n == n2);
      score = n == n1 ? b : n == n2 ? c : score;
      @(negedge clk);
    end
    score_load = 0;
    chk({name, "_count"}, vals.size(), 2);
    if (vals.size() == 2) begin
      chk({name, "_first"}, 32'(vals[0]), 32'(e0));
      chk({name, "_second"}, 32'(vals[1]), 32'(e1));
      chk({name, "_first_t"}, times[0], 17);
      chk({name, "_second_t"}, times[1], 34);
    end
  endtask
  initial begin
    logic [19:0] r;
    int lat, bcnt, nv;
    logic [15:0] v;
    vecs = '{'{16'd12345, 20'h12345}, '{16'd65535, 20'h65535}, '{16'd0, 20'h00000}, '{16'd9999, 20'h09999},
             '{16'd42, 20'h00042}, '{16'd100, 20'h00100}, '{16'd10, 20'h00010}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(bcd_valid), 0);
    chk("rst_digit_en", 32'(digit_en), 1);
    chk("rst_seg", 32'(seg), 32'h3F);
    for (int j = 1; j <= 3 * RD; j++) begin
      @(negedge clk);
      chk("rotate", 32'(digit_en), 32'(1 << ((j / RD) % 5)));
    end
    foreach (vecs[i]) begin
      do_conv(vecs[i].s, r, lat, bcnt);
      chk($sformatf("vec_bcd_%0d", vecs[i].s), 32'(r), 32'(vecs[i].e));
      chk($sformatf("vec_lat_%0d", vecs[i].s), lat, 17);
      chk($sformatf("vec_busy_%0d", vecs[i].s), bcnt, 17);
      @(negedge clk);
      chk("valid_single", 32'(bcd_valid), 0);
      chk("busy_drop", 32'(busy), 0);
      if (vecs[i].s == 16'd42 || vecs[i].s == 16'd10) check_scan(vecs[i].e);
    end
    for (int i = 0; i < 15; i++) begin
      v = 16'($urandom_range(0, 65535));
      do_conv(v, r, lat, bcnt);
      chk($sformatf("rand_bcd_%0d", v), 32'(r), 32'(to_bcd(int'(v))));
      chk("rand_lat", lat, 17);
      if (i == 0) check_scan(to_bcd(int'(v)));
    end
    repeat (2) @(negedge clk);
    seq(16'd100, 2, 16'd200, 4, 16'd300, 20'h00100, 20'h00300, "pend");
    seq(16'd100, 16, 16'd55, -1, 16'd0, 20'h00100, 20'h00055, "done_load");
    score = 500;
    score_load = 1;
    @(posedge clk);
    @(negedge clk);
    score_load = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_bcd", 32'(bcd), 0);
    chk("abort_valid", 32'(bcd_valid), 0);
    nv = 0;
    for (int n = 0; n < 25; n++) begin
      if (bcd_valid) nv++;
      @(negedge clk);
    end
    chk("abort_no_valid", nv, 0);
    do_conv(16'd7, r, lat, bcnt);
    chk("after_abort_bcd", 32'(r), 32'h00007);
    chk("after_abort_lat", lat, 17);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
